alu_share_arbiter: RTL

- Shares the single-cycle 32-bit ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch-compare unit.
- Each cycle it grants at most one request using round-robin priority and drives the ALU combinationally.
- It registers the result with its zero and negative flags into a one-deep response slot owned by the winning requester.
- The opcode set is fixed: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLTU, 101 SLT, 110 XOR; 111 is illegal.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu.sv | 26 ++
 rtl/alu_rsp_slot.sv | 67 ++++++
 rtl/alu_share_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-port ALU share arbiter.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int OPC_W  = 3;

  localparam logic [OPC_W-1:0] ALU_ADD     = 3'b000;
  localparam logic [OPC_W-1:0] ALU_SUB     = 3'b001;
  localparam logic [OPC_W-1:0] ALU_AND     = 3'b010;
  localparam logic [OPC_W-1:0] ALU_OR      = 3'b011;
  localparam logic [OPC_W-1:0] ALU_SLTU    = 3'b100;
  localparam logic [OPC_W-1:0] ALU_SLT     = 3'b101;
  localparam logic [OPC_W-1:0] ALU_XOR     = 3'b110;
  localparam logic [OPC_W-1:0] ALU_ILLEGAL = 3'b111;

  // One response as it is loaded into a slot
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              neg;
    logic              err;
  } alu_rsp_t;
endpackage

// File: rtl/alu.sv
// Single-cycle 32-bit ALU (combinational, no carry/overflow output).
module alu
  import alu_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  // Opcode decode; the illegal opcode yields zero here and is flagged by the caller
  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_XOR:  result = a ^ b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rsp_slot.sv
// One-deep response holding register: load wins over drain, data holds on drain.
module alu_rsp_slot
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_result,
  input  logic              ld_zero,
  input  logic              ld_neg,
  input  logic              ld_err,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_err
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic              err_q, err_d;

  // Next-state: refill in the same cycle as a drain is allowed
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    err_d    = err_q;
    if (load) begin
      valid_d  = 1'b1;
      result_d = ld_result;
      zero_d   = ld_zero;
      neg_d    = ld_neg;
      err_d    = ld_err;
    end else if (out_ready && valid_q) begin
      valid_d  = 1'b0;
    end
  end

  // Slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_neg    = neg_q;
  assign out_err    = err_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between execute (port 0) and addr/branch unit (port 1).
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,  // ALU is fixed at 32; no other value is legal
  parameter int OPC_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OPC_W-1:0]  req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OPC_W-1:0]  req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp0_neg,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic              rsp1_neg,
  output logic              rsp1_err,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              elig0, elig1;
  logic              grant0, grant1;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OPC_W-1:0]  mux_opc;
  logic [DATA_W-1:0] mux_a, mux_b, alu_res;
  alu_rsp_t          rsp_new;

  // A full slot that is draining this cycle can accept a new result
  assign elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
  assign elig1 = req1_valid && (!rsp1_valid || rsp1_ready);

  // Round-robin: on conflict, the port that did not win last time gets it
  always_comb begin
    grant0       = elig0 && (!elig1 || last_grant_q);
    grant1       = elig1 && (!elig0 || !last_grant_q);
    last_grant_d = last_grant_q;
    if (grant0)      last_grant_d = 1'b0;
    else if (grant1) last_grant_d = 1'b1;
    cnt_d = cnt_q;
    if (elig0 && elig1 && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Operand mux; port 0 is the default when nothing is granted
  always_comb begin
    mux_opc = grant1 ? req1_opcode : req0_opcode;
    mux_a   = grant1 ? req1_a      : req0_a;
    mux_b   = grant1 ? req1_b      : req0_b;
  end

  alu u_alu (
    .opcode (mux_opc),
    .a      (mux_a),
    .b      (mux_b),
    .result (alu_res)
  );

  // Response formation; illegal opcode overrides the ALU output
  always_comb begin
    rsp_new.err    = (mux_opc == ALU_ILLEGAL);
    rsp_new.result = rsp_new.err ? '0 : alu_res;
    rsp_new.zero   = (rsp_new.result == '0);
    rsp_new.neg    = rsp_new.result[DATA_W-1];
  end

  // Arbitration state and conflict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;

  alu_rsp_slot u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (grant0),
    .ld_result  (rsp_new.result),
    .ld_zero    (rsp_new.zero),
    .ld_neg     (rsp_new.neg),
    .ld_err     (rsp_new.err),
    .out_ready  (rsp0_ready),
    .out_valid  (rsp0_valid),
    .out_result (rsp0_result),
    .out_zero   (rsp0_zero),
    .out_neg    (rsp0_neg),
    .out_err    (rsp0_err)
  );

  alu_rsp_slot u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (grant1),
    .ld_result  (rsp_new.result),
    .ld_zero    (rsp_new.zero),
    .ld_neg     (rsp_new.neg),
    .ld_err     (rsp_new.err),
    .out_ready  (rsp1_ready),
    .out_valid  (rsp1_valid),
    .out_result (rsp1_result),
    .out_zero   (rsp1_zero),
    .out_neg    (rsp1_neg),
    .out_err    (rsp1_err)
  );

endmodule
